// File: rtl/ex_mem_if.sv
// ex_mem_if: EX-to-MEM pipeline bus, stall/flush control and madd/msub feedback
interface ex_mem_if;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
  modport master (
    output stall, flush, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
           ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
           mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o
  );
  modport slave (
    input  stall, flush, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
           ex_aluop, ex_mem_addr, ex_reg2, hilo_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
           mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o
  );
endinterface

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register with flush, bubble, hold and madd/msub feedback
module ex_mem (
    input logic clk,
    input logic rst,
    ex_mem_if.slave b
);
    logic unused_stall;
    assign unused_stall = ^{b.stall[5], b.stall[2:0]};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || b.flush) begin
            b.mem_wd       <= '0;
            b.mem_wreg     <= 1'b0;
            b.mem_wdata    <= '0;
            b.mem_whilo    <= 1'b0;
            b.mem_hi       <= '0;
            b.mem_lo       <= '0;
            b.mem_aluop    <= '0;
            b.mem_mem_addr <= '0;
            b.mem_reg2     <= '0;
            b.hilo_o       <= '0;
            b.cnt_o        <= '0;
        end else if (!b.stall[3]) begin
            // stall[4] without stall[3] cannot occur legally; it advances too
            b.mem_wd       <= b.ex_wd;
            b.mem_wreg     <= b.ex_wreg;
            b.mem_wdata    <= b.ex_wdata;
            b.mem_whilo    <= b.ex_whilo;
            b.mem_hi       <= b.ex_hi;
            b.mem_lo       <= b.ex_lo;
            b.mem_aluop    <= b.ex_aluop;
            b.mem_mem_addr <= b.ex_mem_addr;
            b.mem_reg2     <= b.ex_reg2;
            b.hilo_o       <= '0;
            b.cnt_o        <= '0;
        end else if (!b.stall[4]) begin
            b.mem_wd       <= '0;
            b.mem_wreg     <= 1'b0;
            b.mem_wdata    <= '0;
            b.mem_whilo    <= 1'b0;
            b.mem_hi       <= '0;
            b.mem_lo       <= '0;
            b.mem_aluop    <= '0;
            b.mem_mem_addr <= '0;
            b.mem_reg2     <= '0;
            b.hilo_o       <= b.hilo_i;
            b.cnt_o        <= b.cnt_i;
        end else begin
            b.hilo_o       <= b.hilo_i;
            b.cnt_o        <= b.cnt_i;
        end
    end
endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: directed vectors for the EX/MEM pipeline register
module tb_ex_mem;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errs = 0;
    int   n = 0;
    ex_mem_if b();
    ex_mem dut (.clk(clk), .rst(rst), .b(b.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".wd"},    {59'd0, b.mem_wd}, 64'd0);
        chk({tag, ".wreg"},  {63'd0, b.mem_wreg}, 64'd0);
        chk({tag, ".wdata"}, {32'd0, b.mem_wdata}, 64'd0);
        chk({tag, ".whilo"}, {63'd0, b.mem_whilo}, 64'd0);
        chk({tag, ".hilo"},  {b.mem_hi, b.mem_lo}, 64'd0);
        chk({tag, ".aluop"}, {56'd0, b.mem_aluop}, 64'd0);
        chk({tag, ".addr"},  {32'd0, b.mem_mem_addr}, 64'd0);
        chk({tag, ".reg2"},  {32'd0, b.mem_reg2}, 64'd0);
        chk({tag, ".hilo_o"}, b.hilo_o, 64'd0);
        chk({tag, ".cnt_o"}, {62'd0, b.cnt_o}, 64'd0);
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        b.stall = '0; b.flush = 1'b0;
        b.ex_wd = 5'd9; b.ex_wreg = 1'b1; b.ex_wdata = 32'hAAAA_5555;
        b.ex_whilo = 1'b1; b.ex_hi = 32'h1; b.ex_lo = 32'h2; b.ex_aluop = 8'h21;
        b.ex_mem_addr = 32'h10; b.ex_reg2 = 32'h20; b.hilo_i = 64'h77; b.cnt_i = 2'd3;
        step;
        chk_zero("reset");
        rst = 1'b1;
        b.ex_wd = 5'd3; b.ex_wreg = 1'b1; b.ex_wdata = 32'h0000_1234;
        b.hilo_i = 64'h5; b.cnt_i = 2'd2;
        step;
        chk("adv.wd", {59'd0, b.mem_wd}, 64'd3);
        chk("adv.wreg", {63'd0, b.mem_wreg}, 64'd1);
        chk("adv.wdata", {32'd0, b.mem_wdata}, 64'h1234);
        chk("adv.cnt_o", {62'd0, b.cnt_o}, 64'd0);
        chk("adv.hilo_o", b.hilo_o, 64'd0);
        b.ex_aluop = 8'hEB; b.ex_mem_addr = 32'h0000_0040; b.ex_reg2 = 32'h1122_3344;
        b.ex_whilo = 1'b1; b.ex_hi = 32'hCAFE_0001; b.ex_lo = 32'hCAFE_0002;
        step;
        chk("st.aluop", {56'd0, b.mem_aluop}, 64'hEB);
        chk("st.addr", {32'd0, b.mem_mem_addr}, 64'h40);
        chk("st.reg2", {32'd0, b.mem_reg2}, 64'h1122_3344);
        chk("st.whilo", {63'd0, b.mem_whilo}, 64'd1);
        chk("st.hilo", {b.mem_hi, b.mem_lo}, 64'hCAFE_0001_CAFE_0002);
        b.stall = 6'b001111; b.hilo_i = 64'h0000_0001_0000_0002; b.cnt_i = 2'd1;
        step;
        chk("bub.wreg", {63'd0, b.mem_wreg}, 64'd0);
        chk("bub.wd", {59'd0, b.mem_wd}, 64'd0);
        chk("bub.aluop", {56'd0, b.mem_aluop}, 64'd0);
        chk("bub.hilo_o", b.hilo_o, 64'h0000_0001_0000_0002);
        chk("bub.cnt_o", {62'd0, b.cnt_o}, 64'd1);
        b.hilo_i = 64'h0000_0003_0000_0004; b.cnt_i = 2'd2;
        step;
        chk_zero_mem_only: begin
            chk("bub2.wreg", {63'd0, b.mem_wreg}, 64'd0);
            chk("bub2.wdata", {32'd0, b.mem_wdata}, 64'd0);
        end
        chk("bub2.hilo_o", b.hilo_o, 64'h0000_0003_0000_0004);
        chk("bub2.cnt_o", {62'd0, b.cnt_o}, 64'd2);
        b.stall = '0; b.ex_wdata = 32'hDEAD_BEEF; b.ex_wd = 5'd7;
        step;
        chk("load.wdata", {32'd0, b.mem_wdata}, 64'hDEAD_BEEF);
        b.stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            b.ex_wdata = 32'h100 + i; b.ex_wd = 5'(i); b.cnt_i = 2'(i + 1);
            b.hilo_i = 64'h900 + 64'(i);
            step;
            chk($sformatf("hold%0d.wdata", i), {32'd0, b.mem_wdata}, 64'hDEAD_BEEF);
            chk($sformatf("hold%0d.wd", i), {59'd0, b.mem_wd}, 64'd7);
            chk($sformatf("hold%0d.cnt_o", i), {62'd0, b.cnt_o}, 64'(i + 1));
            chk($sformatf("hold%0d.hilo_o", i), b.hilo_o, 64'h900 + 64'(i));
        end
        b.stall = 6'b010000; b.ex_wdata = 32'h55; b.cnt_i = 2'd3;
        step;
        chk("illegal.wdata", {32'd0, b.mem_wdata}, 64'h55);
        chk("illegal.cnt_o", {62'd0, b.cnt_o}, 64'd0);
        b.stall = 6'b011111; b.flush = 1'b1; b.hilo_i = 64'hFFFF_0000_1234_5678; b.cnt_i = 2'd3;
        step;
        chk_zero("flush");
        b.flush = 1'b0; b.stall = '0; b.ex_wdata = 32'h0BAD_F00D; b.ex_wd = 5'd31;
        step;
        b.stall = 6'b011111; b.hilo_i = 64'h1234; b.cnt_i = 2'd2;
        step;
        chk("pre_rst.wdata", {32'd0, b.mem_wdata}, 64'h0BAD_F00D);
        chk("pre_rst.hilo_o", b.hilo_o, 64'h1234);
        #2 rst = 1'b0;
        #1 chk_zero("async");
        b.stall = '0;
        step;
        chk_zero("rst_held");
        rst = 1'b1; b.ex_wdata = 32'h0000_00C3; b.ex_wd = 5'd4;
        step;
        chk("post_rst.wdata", {32'd0, b.mem_wdata}, 64'hC3);
        chk("post_rst.wd", {59'd0, b.mem_wd}, 64'd4);
        $display("Result: errors=%0d of %0d checks", errs, n);
        $finish;
    end
endmodule
